// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - programmable serial pattern detector with overlap/Mealy-Moore select
// Saturating match counter included; all state updates on the rising edge of clk_i.
module seq_detector_param #(
  parameter int                 PAT_W       = 4,
  parameter logic [PAT_W-1:0]   DEFAULT_PAT = 4'b1011,
  parameter int                 CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_i,
  input  logic             in_valid_i,
  input  logic             pat_load_i,
  input  logic [PAT_W-1:0] pat_in_i,
  input  logic             overlap_en_i,
  input  logic             moore_mode_i,
  input  logic             cnt_clr_i,
  output logic             out_o,
  output logic [CNT_W-1:0] match_cnt_o
);

  localparam int                FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] window;
  logic             hit;

  // Candidate window: stored history with the current bit appended as LSB.
  assign window = {hist_q, in_i};
  assign hit    = in_valid_i & ~pat_load_i & ~reset_i &
                  (fill_q == FILL_MAX) & (window == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = hit;
    cnt_d  = cnt_q;

    if (pat_load_i) begin
      pat_d  = pat_in_i;
      fill_d = '0;
    end else if (in_valid_i) begin
      hist_d = window[PAT_W-2:0];
      if (hit && !overlap_en_i) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
    end

    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (hit && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pat_q  <= DEFAULT_PAT;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_o       = reset_i ? 1'b0 : (moore_mode_i ? out_q : hit);
  assign match_cnt_o = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - self-checking bench for seq_detector_param
// Directed scenarios followed by randomized traffic against a queue-based reference model.
module tb_seq_detector_param;

  localparam int PAT_W   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [PAT_W-1:0] DEF_PAT = 4'b1011;

  logic             clk;
  logic             reset;
  logic             in_bit;
  logic             in_valid;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             overlap_en;
  logic             moore_mode;
  logic             cnt_clr;
  logic             out_w;
  logic [CNT_W-1:0] match_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: the fresh valid bits since the last restart, newest at the back.
  int          m_bits[$];
  int          m_pat;
  int          m_cnt;
  bit          m_prev_hit;
  int          m_hits;

  seq_detector_param #(
    .PAT_W(PAT_W), .DEFAULT_PAT(DEF_PAT), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .reset_i(reset), .in_i(in_bit), .in_valid_i(in_valid),
    .pat_load_i(pat_load), .pat_in_i(pat_in), .overlap_en_i(overlap_en),
    .moore_mode_i(moore_mode), .cnt_clr_i(cnt_clr),
    .out_o(out_w), .match_cnt_o(match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check out against the model, clock, check the counter.
  task automatic step(input bit b, input bit v, input bit ld = 0, input int pi = 0,
                      input bit clr = 0, input bit rst = 0);
    int  tmp[$];
    int  val;
    bit  hit;
    tmp      = m_bits;
    hit      = 0;
    in_bit   = b;
    in_valid = v;
    pat_load = ld;
    pat_in   = PAT_W'(pi);
    cnt_clr  = clr;
    reset    = rst;
    if (!rst && !ld && v) begin
      tmp.push_back(int'(b));
      if (tmp.size() > PAT_W) void'(tmp.pop_front());
      if (tmp.size() == PAT_W) begin
        val = 0;
        foreach (tmp[i]) val = val * 2 + tmp[i];
        hit = (val == m_pat);
      end
    end
    #2;
    check("out", int'(out_w), rst ? 0 : (moore_mode ? int'(m_prev_hit) : int'(hit)));
    @(posedge clk);
    #1;
    if (rst) begin
      m_bits.delete();
      m_pat      = int'(DEF_PAT);
      m_cnt      = 0;
      m_prev_hit = 0;
    end else begin
      if (ld) begin
        m_pat = pi;
        m_bits.delete();
      end else if (v) begin
        m_bits = tmp;
        if (hit && !overlap_en) m_bits.delete();
      end
      m_prev_hit = hit;
      if (clr) m_cnt = 0;
      else if (hit && m_cnt < CNT_MAX) m_cnt++;
    end
    if (hit) m_hits++;
    check("match_cnt", int'(match_cnt), m_cnt);
  endtask

  task automatic send(input int bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bit'((bits >> i) & 1), 1'b1);
  endtask

  initial begin
    in_bit = 0; in_valid = 0; pat_load = 0; pat_in = '0;
    overlap_en = 1; moore_mode = 0; cnt_clr = 0; reset = 1;
    m_pat = int'(DEF_PAT); m_cnt = 0; m_prev_hit = 0; m_hits = 0;
    @(posedge clk); #1;

    // Reset state
    step(1, 1, 0, 0, 0, 1);
    check("reset_cnt", int'(match_cnt), 0);

    // Overlapping Mealy: 1011011 -> hits on bits 4 and 7
    m_hits = 0;
    send(7'b1011011, 7);
    check("t1_cnt", int'(match_cnt), 2);
    check("t1_hits", m_hits, 2);

    // Non-overlapping
    step(0, 0, 0, 0, 0, 1);
    overlap_en = 0;
    send(7'b1011011, 7);
    check("t2_cnt", int'(match_cnt), 1);
    overlap_en = 1;

    // Moore: pulse appears the cycle after the final bit
    step(0, 0, 0, 0, 0, 1);
    moore_mode = 1;
    send(4'b1011, 4);
    check("t3_out_late", int'(out_w), 1);
    step(0, 0);
    check("t3_out_gone", int'(out_w), 0);
    moore_mode = 0;

    // Idle gaps do not break the pattern
    step(0, 0, 0, 0, 0, 1);
    send(2'b10, 2);
    repeat (3) step(1, 0);
    m_hits = 0;
    send(2'b11, 2);
    check("t4_hits", m_hits, 1);
    check("t4_cnt", int'(match_cnt), 1);

    // All-zero pattern, saturation and clear-over-hit priority
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 0);
    repeat (260) step(0, 1);
    check("t5_sat", int'(match_cnt), CNT_MAX);
    step(0, 1, 0, 0, 1);
    check("t5_clr", int'(match_cnt), 0);

    // Reset mid-pattern discards history
    step(0, 0, 0, 0, 0, 1);
    send(3'b101, 3);
    step(0, 0, 0, 0, 0, 1);
    m_hits = 0;
    step(1, 1);
    check("t6_nomatch", m_hits, 0);
    send(4'b1011, 4);
    check("t6_match", m_hits, 1);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 49) == 0) overlap_en = ~overlap_en;
      if ($urandom_range(0, 39) == 0) moore_mode = ~moore_mode;
      step(bit'($urandom_range(0, 1)),
           $urandom_range(0, 5) != 0,
           $urandom_range(0, 79) == 0,
           int'($urandom_range(0, (1 << PAT_W) - 1)),
           $urandom_range(0, 149) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
